// File: rtl/vga_capture.sv
// VGA sink: registers sync/RGB, measures line/frame timing, locks onto a stable mode and
// emits qualified pixels with coordinates. Define VGA_CAPTURE_CRC_EN to build the per-frame CRC.
module vga_capture #(
  parameter int H_SYNC_POL   = 1,
  parameter int V_SYNC_POL   = 1,
  parameter int H_BACK       = 64,
  parameter int H_ACTIVE     = 800,
  parameter int V_BACK       = 23,
  parameter int V_ACTIVE     = 600,
  parameter int LOCK_FRAMES  = 2,
  parameter int TIMEOUT_BITS = 21
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  r_in,
  input  logic [3:0]  g_in,
  input  logic [3:0]  b_in,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic [3:0]  pix_r,
  output logic [3:0]  pix_g,
  output logic [3:0]  pix_b,
  output logic        frame_start,
  output logic        locked,
  output logic [11:0] line_len,
  output logic [10:0] frame_lines,
  output logic [15:0] frame_crc
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic        HS_ACT  = (H_SYNC_POL != 0);
  localparam logic        VS_ACT  = (V_SYNC_POL != 0);
  localparam logic [11:0] H_LO    = 12'(H_BACK);
  localparam logic [11:0] H_HI    = 12'(H_BACK + H_ACTIVE);
  localparam logic [10:0] V_LO    = 11'(V_BACK);
  localparam logic [10:0] V_HI    = 11'(V_BACK + V_ACTIVE);
  // The frame that loads the reference counts as the first of the identical frames.
  localparam logic [2:0]  LOCK_AT = 3'(LOCK_FRAMES - 1);

  // ---------------------------------------------------------------------------
  // Input stage S1: syncs normalised to "asserted = 1"
  // ---------------------------------------------------------------------------
  logic        hs1, vs1, hs1_d, vs1_d;
  logic [11:0] rgb1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      hs1_d <= 1'b0;
      vs1_d <= 1'b0;
      rgb1  <= '0;
    end else begin
      hs1   <= (hsync == HS_ACT);
      vs1   <= (vsync == VS_ACT);
      hs1_d <= hs1;
      vs1_d <= vs1;
      rgb1  <= {r_in, g_in, b_in};
    end
  end

  logic hs_rise, hs_fall, vs_rise, vs_fall;

  assign hs_rise = hs1 & ~hs1_d;
  assign hs_fall = ~hs1 & hs1_d;
  assign vs_rise = vs1 & ~vs1_d;
  assign vs_fall = ~vs1 & vs1_d;

  // ---------------------------------------------------------------------------
  // Position of the sample currently in S1
  // ---------------------------------------------------------------------------
  logic [11:0] hcnt, h_cur;
  logic [10:0] vline, v_cur;

  // NOTE: combinational blocks assign every output a default first so no path infers a latch.
  always_comb begin
    h_cur = (hcnt == '1) ? hcnt : hcnt + 12'd1;
    if (hs_fall) h_cur = '0;
    v_cur = vline;
    if (vs_fall) begin
      v_cur = '0;
    end else if (hs_rise && (vline != '1)) begin
      v_cur = vline + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt  <= '0;
      vline <= '0;
    end else begin
      hcnt  <= h_cur;
      vline <= v_cur;
    end
  end

  logic in_window, at_origin;

  assign in_window = (h_cur >= H_LO) && (h_cur < H_HI) && (v_cur >= V_LO) && (v_cur < V_HI);
  assign at_origin = (h_cur == H_LO) && (v_cur == V_LO);

  // ---------------------------------------------------------------------------
  // Line / frame measurement
  // ---------------------------------------------------------------------------
  logic [11:0] per_cnt, ll_new;
  logic [10:0] fl_cnt, fl_inc;

  assign fl_inc = (hs_rise && (fl_cnt != '1)) ? fl_cnt + 11'd1 : fl_cnt;
  assign ll_new = hs_rise ? per_cnt : line_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt     <= '0;
      line_len    <= '0;
      fl_cnt      <= '0;
      frame_lines <= '0;
    end else begin
      if (hs_rise) begin
        per_cnt  <= 12'd1;
        line_len <= per_cnt;
      end else if (per_cnt != '1) begin
        per_cnt  <= per_cnt + 12'd1;
      end
      fl_cnt <= vs_rise ? '0 : fl_inc;
      if (vs_rise) frame_lines <= fl_inc;
    end
  end

  // ---------------------------------------------------------------------------
  // Loss-of-vsync watchdog
  // ---------------------------------------------------------------------------
  logic [TIMEOUT_BITS-1:0] wd_cnt;
  logic                    timeout;

  assign timeout = &wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (vs_rise) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + TIMEOUT_BITS'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM, evaluated on each vsync assert edge
  // ---------------------------------------------------------------------------
  state_t      state, state_n;
  logic [2:0]  match_cnt, match_n, match_inc;
  logic [11:0] ref_len, ref_len_n;
  logic [10:0] ref_lines, ref_lines_n;
  logic        same, reload;

  always_comb begin
    state_n     = state;
    match_n     = match_cnt;
    ref_len_n   = ref_len;
    ref_lines_n = ref_lines;
    reload      = 1'b0;
    same        = (ll_new == ref_len) && (fl_inc == ref_lines);
    match_inc   = (match_cnt == 3'd7) ? match_cnt : match_cnt + 3'd1;

    if (vs_rise) begin
      case (state)
        SEARCH: begin
          state_n = MEASURE;
          reload  = 1'b1;
        end
        MEASURE: begin
          if (same) begin
            match_n = match_inc;
            if (match_inc >= LOCK_AT) state_n = LOCKED;
          end else begin
            reload = 1'b1;
          end
        end
        LOCKED: begin
          if (!same) begin
            state_n = MEASURE;
            reload  = 1'b1;
          end
        end
        default: state_n = SEARCH;
      endcase
    end else if (timeout) begin
      state_n = SEARCH;
      match_n = '0;
    end

    if (reload) begin
      match_n     = '0;
      ref_len_n   = ll_new;
      ref_lines_n = fl_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      match_cnt <= '0;
      ref_len   <= '0;
      ref_lines <= '0;
    end else begin
      state     <= state_n;
      match_cnt <= match_n;
      ref_len   <= ref_len_n;
      ref_lines <= ref_lines_n;
    end
  end

  assign locked = (state == LOCKED);

  // ---------------------------------------------------------------------------
  // Pixel output stage; gated by the next state so a pixel in flight at lock loss is dropped
  // ---------------------------------------------------------------------------
  logic emit;

  assign emit = in_window && (state_n == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_r       <= '0;
      pix_g       <= '0;
      pix_b       <= '0;
    end else begin
      pix_valid   <= emit;
      frame_start <= emit && at_origin;
      if (emit) begin
        pix_x               <= 11'(h_cur - H_LO);
        pix_y               <= 10'(v_cur - V_LO);
        {pix_r, pix_g, pix_b} <= rgb1;
      end
    end
  end

`ifdef VGA_CAPTURE_CRC_EN
  // CRC-16-CCITT over the 12-bit pixel word, MSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [11:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 11; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  logic [15:0] crc_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_run   <= '0;
      frame_crc <= '0;
    end else begin
      if (emit) crc_run <= crc_step(at_origin ? 16'hFFFF : crc_run, rgb1);
      if (vs_rise && (state == LOCKED)) frame_crc <= crc_run;
    end
  end
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a reduced 20x10 timing; expected pixels are queued
// by the stimulus and popped by an independent monitor. Honours VGA_CAPTURE_CRC_EN.
module tb_vga_capture;

  localparam int HT  = 20;  // clocks per line
  localparam int HS  = 3;   // hsync width
  localparam int HB  = 4;
  localparam int HA  = 8;
  localparam int VT  = 10;  // lines per frame
  localparam int VS  = 2;   // vsync width in lines
  localparam int VB  = 2;
  localparam int VA  = 4;
  localparam int TOB = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic [3:0]  r_in = '0, g_in = '0, b_in = '0;
  logic        pix_valid, frame_start, locked;
  logic [10:0] pix_x, frame_lines;
  logic [9:0]  pix_y;
  logic [3:0]  pix_r, pix_g, pix_b;
  logic [11:0] line_len;
  logic [15:0] frame_crc;

  always #5 clk = ~clk;

  vga_capture #(
    .H_SYNC_POL(1), .V_SYNC_POL(1), .H_BACK(HB), .H_ACTIVE(HA),
    .V_BACK(VB), .V_ACTIVE(VA), .LOCK_FRAMES(2), .TIMEOUT_BITS(TOB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .frame_start(frame_start), .locked(locked), .line_len(line_len),
    .frame_lines(frame_lines), .frame_crc(frame_crc)
  );

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic [11:0] rgb;
    logic        fs;
  } pix_t;

  pix_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          valid_seen = 0;
  logic [15:0] crc_model;
  logic        snap_locked;
  logic [11:0] snap_ll;
  logic [10:0] snap_fl;
  logic [15:0] snap_crc;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] crc12(input logic [15:0] crc, input logic [11:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 11; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [15:0] exp_crc(input logic [15:0] m);
`ifdef VGA_CAPTURE_CRC_EN
    return m;
`else
    return m & 16'h0000;
`endif
  endfunction

  // Monitor: every presented pixel must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && pix_valid) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", 96'(pix_valid), 96'd0);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        check("pixel", 96'({pix_x, pix_y, pix_r, pix_g, pix_b, frame_start}), 96'(e));
      end
    end else if (rst_n && frame_start) begin
      check("stray_frame_start", 96'(frame_start), 96'd0);
    end
  end

  // One frame; exp_on queues its active pixels. abort_k >= 0 pulses reset at that clock.
  task automatic drive_frame(input int fid, input bit exp_on, input int stretch,
                             input int abort_k, input bit const_col);
    int          k;
    int          len;
    int          tmp;
    logic [11:0] col;
    pix_t        e;
    k = 0;
    crc_model = 16'hFFFF;
    for (int l = 0; l < VT; l++) begin
      len = HT + ((l == VT - 1) ? stretch : 0);
      for (int c = 0; c < len; c++) begin
        @(posedge clk);
        #1;
        tmp = fid * 291 + l * 37 + c * 11;
        col = const_col ? 12'hF00 : tmp[11:0];
        hsync = (c < HS);
        vsync = (l < VS);
        {r_in, g_in, b_in} = col;
        if (exp_on && (l >= VS + VB) && (l < VS + VB + VA) && (c >= HS + HB) &&
            (c < HS + HB + HA) && ((abort_k < 0) || (k < abort_k - 2))) begin
          e.x   = 11'(c - HS - HB);
          e.y   = 10'(l - VS - VB);
          e.rgb = col;
          e.fs  = (e.x == 11'd0) && (e.y == 10'd0);
          exp_q.push_back(e);
          crc_model = crc12(e.fs ? 16'hFFFF : crc_model, col);
        end
        if (k == 5) begin
          snap_locked = locked;
          snap_ll     = line_len;
          snap_fl     = frame_lines;
          snap_crc    = frame_crc;
        end
        if (k == abort_k) begin
          #2 rst_n = 1'b0;
          #1 check("reset_mid_line", 96'({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b,
                   frame_start, locked, line_len, frame_lines, frame_crc}), 96'd0);
        end
        if ((abort_k >= 0) && (k == abort_k + 3)) rst_n = 1'b1;
        k++;
      end
    end
  endtask

  task automatic hold_lines(input int n);
    for (int l = 0; l < n; l++) begin
      for (int c = 0; c < HT; c++) begin
        @(posedge clk);
        #1;
        hsync = (c < HS);
        vsync = 1'b0;
        {r_in, g_in, b_in} = 12'(l * 7 + c);
      end
    end
  endtask

  initial begin
    int          vs0;
    logic [15:0] prev;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 96'({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_start,
          locked, line_len, frame_lines, frame_crc}), 96'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Acquisition: lock after the third V-edge.
    drive_frame(1, 1'b0, 0, -1, 1'b0);
    check("edge1_unlocked", 96'(snap_locked), 96'd0);
    drive_frame(2, 1'b0, 0, -1, 1'b0);
    check("edge2_unlocked", 96'(snap_locked), 96'd0);
    vs0 = valid_seen;
    drive_frame(3, 1'b1, 0, -1, 1'b0);
    check("edge3_locked", 96'(snap_locked), 96'd1);
    check("line_len", 96'(snap_ll), 96'(HT));
    check("frame_lines", 96'(snap_fl), 96'(VT));
    check("frame3_count", 96'(valid_seen - vs0), 96'(HA * VA));
    prev = crc_model;

    vs0 = valid_seen;
    drive_frame(4, 1'b1, 0, -1, 1'b1);
    check("frame4_count", 96'(valid_seen - vs0), 96'(HA * VA));
    check("frame3_crc", 96'(snap_crc), 96'(exp_crc(prev)));
    prev = crc_model;

    // Last line of frame 5 stretched by one clock.
    drive_frame(5, 1'b1, 1, -1, 1'b0);
    check("const_colour_crc", 96'(snap_crc), 96'(exp_crc(prev)));
    check("frame5_locked", 96'(snap_locked), 96'd1);
    prev = crc_model;
    drive_frame(6, 1'b0, 0, -1, 1'b0);
    check("stretched_len", 96'(snap_ll), 96'(HT + 1));
    check("lock_lost", 96'(snap_locked), 96'd0);
    check("frame5_crc", 96'(snap_crc), 96'(exp_crc(prev)));
    drive_frame(7, 1'b0, 0, -1, 1'b0);
    check("len_restored", 96'(snap_ll), 96'(HT));
    check("still_measuring", 96'(snap_locked), 96'd0);
    vs0 = valid_seen;
    drive_frame(8, 1'b1, 0, -1, 1'b0);
    check("relocked", 96'(snap_locked), 96'd1);
    check("frame8_count", 96'(valid_seen - vs0), 96'(HA * VA));

    // vsync stops: lock holds until the watchdog expires.
    hold_lines(30);
    check("hold_still_locked", 96'(locked), 96'd1);
    hold_lines(30);
    check("timeout_unlocked", 96'(locked), 96'd0);
    check("timeout_search", 96'(dut.state), 96'd0);

    drive_frame(9, 1'b0, 0, -1, 1'b0);
    drive_frame(10, 1'b0, 0, -1, 1'b0);
    check("post_timeout_unlocked", 96'(snap_locked), 96'd0);
    drive_frame(11, 1'b1, 0, -1, 1'b0);
    check("post_timeout_relock", 96'(snap_locked), 96'd1);

    // Reset at pixel (4,2): line 6, clock 11 of the frame.
    drive_frame(12, 1'b1, 0, 6 * HT + HS + HB + 4, 1'b0);
    check("pre_reset_locked", 96'(snap_locked), 96'd1);
    drive_frame(13, 1'b0, 0, -1, 1'b0);
    check("post_reset_search", 96'(snap_locked), 96'd0);
    drive_frame(14, 1'b0, 0, -1, 1'b0);
    vs0 = valid_seen;
    drive_frame(15, 1'b1, 0, -1, 1'b0);
    check("post_reset_relock", 96'(snap_locked), 96'd1);
    check("frame15_count", 96'(valid_seen - vs0), 96'(HA * VA));

    repeat (5) @(negedge clk);
    check("queue_drained", 96'(exp_q.size()), 96'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
